// File: rtl/cathode_scan_decoder.sv
// rtl/cathode_scan_decoder.sv - 7-segment display bus readback decoder
// Waits for each anode/cathode sample to hold steady, decodes it and collects a full frame of digits.
module cathode_scan_decoder #(
   parameter int NUM_DIGITS    = 4,
   parameter int STABLE_CYCLES = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NUM_DIGITS-1:0]   anode,
   input  logic [7:0]              cathode,
   output logic [5*NUM_DIGITS-1:0] symbols,
   output logic                    frame_valid,
   output logic                    pattern_err,
   output logic [NUM_DIGITS-1:0]   digit_mask
);

   localparam int CW = $clog2(STABLE_CYCLES + 1);
   localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [CW-1:0] STABLE_MAX = CW'(STABLE_CYCLES);

   typedef enum logic [1:0] {
      ST_WAIT = 2'd0,
      ST_HOLD = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Returns {unmapped, code}; unmapped patterns decode to 31.
   function automatic logic [5:0] decode_seg(input logic [6:0] p);
      logic [5:0] r;
      case (p)
         7'b1000000: r = {1'b0, 5'd0};
         7'b1111001: r = {1'b0, 5'd1};
         7'b0100100: r = {1'b0, 5'd2};
         7'b0110000: r = {1'b0, 5'd3};
         7'b0011001: r = {1'b0, 5'd4};
         7'b0010010: r = {1'b0, 5'd5};
         7'b0000010: r = {1'b0, 5'd6};
         7'b1111000: r = {1'b0, 5'd7};
         7'b0000000: r = {1'b0, 5'd8};
         7'b0010000: r = {1'b0, 5'd9};
         7'b0001000: r = {1'b0, 5'd10};
         7'b0000011: r = {1'b0, 5'd11};
         7'b1000110: r = {1'b0, 5'd12};
         7'b0100001: r = {1'b0, 5'd13};
         7'b0000110: r = {1'b0, 5'd14};
         7'b0001110: r = {1'b0, 5'd15};
         7'b0001100: r = {1'b0, 5'd16};
         7'b0111111: r = {1'b0, 5'd17};
         default:    r = {1'b1, 5'd31};
      endcase
      return r;
   endfunction

   logic [NUM_DIGITS-1:0]   anode_s1_q,   anode_s1_d;
   logic [6:0]              cath_s1_q,    cath_s1_d;
   logic [NUM_DIGITS-1:0]   anode_prev_q, anode_prev_d;
   logic [6:0]              cath_prev_q,  cath_prev_d;
   logic [CW-1:0]           cnt_q,        cnt_d;
   state_t                  state_q,      state_d;
   logic [5*NUM_DIGITS-1:0] slots_q,      slots_d;
   logic [NUM_DIGITS-1:0]   mask_q,       mask_d;
   logic [5*NUM_DIGITS-1:0] symbols_q,    symbols_d;
   logic                    frame_valid_q, frame_valid_d;
   logic                    pattern_err_q, pattern_err_d;

   logic                    anode_valid;
   logic                    changed;
   logic                    capture;
   logic                    publish;
   logic [IW-1:0]           idx;
   logic [5:0]              dec;
   int                      low_cnt;

   always_comb begin
      anode_s1_d   = anode;
      cath_s1_d    = cathode[6:0];
      anode_prev_d = anode_s1_q;
      cath_prev_d  = cath_s1_q;

      low_cnt = 0;
      idx     = '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (!anode_s1_q[i]) begin
            low_cnt = low_cnt + 1;
            idx     = IW'(i);
         end
      end
      anode_valid = (low_cnt == 1);
      changed     = ({anode_s1_q, cath_s1_q} != {anode_prev_q, cath_prev_q});
      dec         = decode_seg(cath_s1_q);

      // Blanking or ghosted anodes never count toward stability.
      if (!anode_valid) begin
         cnt_d = '0;
      end else if (changed || (cnt_q == '0)) begin
         cnt_d = CW'(1);
      end else if (cnt_q < STABLE_MAX) begin
         cnt_d = cnt_q + CW'(1);
      end else begin
         cnt_d = cnt_q;
      end

      state_d = state_q;
      capture = 1'b0;
      case (state_q)
         ST_WAIT: begin
            if (anode_valid) begin
               state_d = ST_HOLD;
            end
         end
         ST_HOLD: begin
            if (!anode_valid) begin
               state_d = ST_WAIT;
            end else if (cnt_d == STABLE_MAX) begin
               capture = 1'b1;
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            if (!anode_valid) begin
               state_d = ST_WAIT;
            end else if (changed) begin
               state_d = ST_HOLD;
            end
         end
         default: state_d = ST_WAIT;
      endcase

      // Publish first, then let a same-edge capture open the next frame.
      publish       = &mask_q;
      symbols_d     = publish ? slots_q : symbols_q;
      frame_valid_d = publish;
      mask_d        = publish ? '0 : mask_q;
      slots_d       = slots_q;
      pattern_err_d = 1'b0;
      if (capture) begin
         slots_d[idx*5 +: 5] = dec[4:0];
         mask_d[idx]         = 1'b1;
         pattern_err_d       = dec[5];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         anode_s1_q    <= '1;
         cath_s1_q     <= '1;
         anode_prev_q  <= '1;
         cath_prev_q   <= '1;
         cnt_q         <= '0;
         state_q       <= ST_WAIT;
         slots_q       <= '1;
         mask_q        <= '0;
         symbols_q     <= '1;
         frame_valid_q <= 1'b0;
         pattern_err_q <= 1'b0;
      end else begin
         anode_s1_q    <= anode_s1_d;
         cath_s1_q     <= cath_s1_d;
         anode_prev_q  <= anode_prev_d;
         cath_prev_q   <= cath_prev_d;
         cnt_q         <= cnt_d;
         state_q       <= state_d;
         slots_q       <= slots_d;
         mask_q        <= mask_d;
         symbols_q     <= symbols_d;
         frame_valid_q <= frame_valid_d;
         pattern_err_q <= pattern_err_d;
      end
   end

   assign symbols     = symbols_q;
   assign frame_valid = frame_valid_q;
   assign pattern_err = pattern_err_q;
   assign digit_mask  = mask_q;

endmodule

// File: tb/tb_cathode_scan_decoder.sv
// tb/tb_cathode_scan_decoder.sv - scoreboard bench for cathode_scan_decoder
// Run-length reference model feeds expected frames and error digits to an output monitor.
module tb_cathode_scan_decoder;

   localparam int N  = 4;
   localparam int SC = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic [N-1:0]  anode;
   logic [7:0]    cathode;
   logic [5*N-1:0] symbols;
   logic          frame_valid;
   logic          pattern_err;
   logic [N-1:0]  digit_mask;

   always #5 clk = ~clk;

   cathode_scan_decoder #(.NUM_DIGITS(N), .STABLE_CYCLES(SC)) dut (
      .clk        (clk),
      .rst        (rst),
      .anode      (anode),
      .cathode    (cathode),
      .symbols    (symbols),
      .frame_valid(frame_valid),
      .pattern_err(pattern_err),
      .digit_mask (digit_mask)
   );

   int checks = 0;
   int errors = 0;
   int fv_count = 0;

   logic [6:0] pat_tbl [18] = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001, 7'b0010010,
      7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
      7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110, 7'b0001100, 7'b0111111};

   logic [5*N-1:0] exp_frame_q [$];
   int             exp_err_q [$];

   int         m_run;
   logic [10:0] m_prev;
   logic [4:0] m_slots [N];
   logic [N-1:0] m_mask;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   function automatic int lookup(input logic [6:0] p);
      for (int i = 0; i < 18; i++) if (pat_tbl[i] == p) return i;
      return 31;
   endfunction

   task automatic model_clear();
      m_run  = 0;
      m_prev = '1;
      m_mask = '0;
   endtask

   task automatic model_step(input logic [N-1:0] an, input logic [6:0] ca);
      int lows, pos, code;
      logic [5*N-1:0] f;
      lows = 0; pos = 0;
      for (int i = 0; i < N; i++) if (!an[i]) begin lows++; pos = i; end
      if (lows != 1) begin
         m_run  = 0;
         m_prev = '1;
         return;
      end
      if (m_run > 0 && {an, ca} == m_prev) m_run++;
      else m_run = 1;
      m_prev = {an, ca};
      if (m_run == SC) begin
         code = lookup(ca);
         if (code == 31) exp_err_q.push_back(pos);
         m_slots[pos] = 5'(code);
         m_mask[pos]  = 1'b1;
         if (&m_mask) begin
            for (int i = 0; i < N; i++) f[i*5 +: 5] = m_slots[i];
            exp_frame_q.push_back(f);
            m_mask = '0;
         end
      end
   endtask

   task automatic drive(input logic [N-1:0] an, input logic [6:0] ca, input int cycles);
      repeat (cycles) begin
         @(negedge clk);
         anode   = an;
         cathode = {1'($urandom_range(0, 1)), ca};
         model_step(an, ca);
      end
   endtask

   task automatic digit(input int d, input int code, input int cycles);
      logic [N-1:0] an;
      an = '1;
      an[d] = 1'b0;
      drive(an, pat_tbl[code], cycles);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst   = 1'b1;
      anode = '1;
      model_clear();
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         if (frame_valid) begin
            fv_count++;
            check("frame_expected", 32'(exp_frame_q.size() > 0), 32'd1);
            if (exp_frame_q.size() > 0) check("frame_symbols", 32'(symbols), 32'(exp_frame_q.pop_front()));
         end
         if (pattern_err) begin
            check("err_expected", 32'(exp_err_q.size() > 0), 32'd1);
            if (exp_err_q.size() > 0) check("err_digit_mask", 32'(digit_mask[exp_err_q.pop_front()]), 32'd1);
         end
      end
   end

   initial begin
      int fv_before;
      logic [N-1:0] ran;
      logic [6:0]   rca;
      rst     = 1'b1;
      anode   = '1;
      cathode = 8'hff;
      model_clear();
      for (int i = 0; i < N; i++) m_slots[i] = 5'd31;
      repeat (3) @(negedge clk);
      check("reset_symbols", 32'(symbols), 32'hfffff);
      check("reset_frame_valid", 32'(frame_valid), 32'd0);
      check("reset_pattern_err", 32'(pattern_err), 32'd0);
      check("reset_digit_mask", 32'(digit_mask), 32'd0);
      rst = 1'b0;

      // 1: basic scan
      for (int d = 0; d < N; d++) digit(d, d + 1, 6);
      drive('1, 7'h7f, 4);
      check("t1_symbols", 32'(symbols), 32'({5'd4, 5'd3, 5'd2, 5'd1}));

      // 2: holds too short to capture
      fv_before = fv_count;
      for (int d = 0; d < N; d++) digit(d, 8, SC - 1);
      drive('1, 7'h7f, 4);
      check("t2_digit_mask", 32'(digit_mask), 32'd0);
      check("t2_no_frame", 32'(fv_count - fv_before), 32'd0);

      // 3: unmapped pattern on digit 2
      digit(0, 9, 5);
      digit(1, 5, 5);
      drive(4'b1011, 7'b1111111, 4);
      digit(3, 6, 5);
      drive('1, 7'h7f, 4);
      check("t3_digit2", 32'(symbols[14:10]), 32'd31);

      // 4: blanking and ghosted anodes
      drive('1, 7'h7f, 3);
      drive(4'b0011, pat_tbl[3], 10);
      check("t4_no_capture", 32'(digit_mask), 32'd0);
      digit(0, 16, 5);
      drive('1, 7'h7f, 3);
      check("t4_mask_p", 32'(digit_mask), 32'b0001);
      for (int d = 1; d < N; d++) digit(d, 10 + d, 5);
      drive('1, 7'h7f, 4);
      check("t4_slot0", 32'(symbols[4:0]), 32'd16);

      // 5: recapture overwrites
      digit(0, 0, 5);
      digit(0, 7, 5);
      for (int d = 1; d < N; d++) digit(d, 17, 5);
      drive('1, 7'h7f, 4);
      check("t5_symbols", 32'(symbols), 32'({5'd17, 5'd17, 5'd17, 5'd7}));

      // 6: reset mid-frame
      for (int d = 0; d < 3; d++) digit(d, d + 4, 6);
      drive('1, 7'h7f, 2);
      check("t6_mask_before", 32'(digit_mask), 32'(m_mask));
      do_reset();
      check("t6_mask_after", 32'(digit_mask), 32'd0);
      check("t6_symbols_after", 32'(symbols), 32'hfffff);
      fv_before = fv_count;
      for (int d = 0; d < N; d++) digit(d, 12 - d, 6);
      drive('1, 7'h7f, 4);
      check("t6_one_frame", 32'(fv_count - fv_before), 32'd1);

      // random scans
      for (int s = 0; s < 300; s++) begin
         if ($urandom_range(0, 99) < 85) begin
            ran = '1;
            ran[$urandom_range(0, N - 1)] = 1'b0;
         end else begin
            ran = 4'($urandom);
         end
         if ($urandom_range(0, 99) < 80) rca = pat_tbl[$urandom_range(0, 17)];
         else rca = 7'($urandom);
         drive(ran, rca, $urandom_range(1, 7));
      end
      drive('1, 7'h7f, 8);
      check("mask_vs_model", 32'(digit_mask), 32'(m_mask));
      check("frames_drained", 32'(exp_frame_q.size()), 32'd0);
      check("errors_drained", 32'(exp_err_q.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
